edge_event_fifo: RTL and testbench

- Downstream consumer for a bank of registered flop outputs (q lanes from dffsr/adff/dffe-style stages).
- Resynchronises the lanes into clk, detects level changes per lane and queues one event per change cycle in a small FIFO.
- FIFO drains over a valid/ready interface to a monitor or bus agent.
- Lets a test harness observe flop-bank behaviour without sampling every cycle.

---
 rtl/edge_event_fifo.sv | 127 ++++++++++++
 tb/tb_edge_event_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_fifo.sv
// Resynchronises a bank of flop lanes, detects per-lane level changes and queues one event per
// change cycle in a show-ahead FIFO. Define EDGE_EVENT_TS_EN to timestamp each entry.
module edge_event_fifo #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TSW   = 8
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [W-1:0]                 d,
    input  logic                         en,
    input  logic                         ovf_clr,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [W-1:0]                 out_mask,
    output logic [W-1:0]                 out_level,
`ifdef EDGE_EVENT_TS_EN
    output logic [TSW-1:0]               out_ts,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  s1_q, s2_q, prev_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [W-1:0]  chg;
    logic          evt, full, push, pop, drop;

    logic [W-1:0]  mask_mem  [DEPTH];
    logic [W-1:0]  level_mem [DEPTH];

`ifdef EDGE_EVENT_TS_EN
    logic [TSW-1:0] ts_q;
    logic [TSW-1:0] ts_mem [DEPTH];
`else
    logic [TSW-1:0] unused_ts;
    assign unused_ts = '0;
`endif

    assign out_valid = (count_q != '0);

    always_comb begin
        chg  = (s2_q ^ prev_q) & {W{en}};
        evt  = |chg;
        full = (count_q == CW'(DEPTH));
        pop  = out_valid & out_ready;
        // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
        push = evt & (~full | pop);
        drop = evt & full & ~pop;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1_q       <= '0;
            s2_q       <= '0;
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef EDGE_EVENT_TS_EN
            ts_q       <= '0;
`endif
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            // prev tracks s2 even when the push is dropped, so a lost change is not re-reported.
            if (en) begin
                prev_q <= s2_q;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef EDGE_EVENT_TS_EN
            ts_q       <= ts_q + TSW'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr_q]  <= chg;
            level_mem[wr_ptr_q] <= s2_q;
`ifdef EDGE_EVENT_TS_EN
            ts_mem[wr_ptr_q]    <= ts_q;
`endif
        end
    end

    assign out_mask  = out_valid ? mask_mem[rd_ptr_q]  : '0;
    assign out_level = out_valid ? level_mem[rd_ptr_q] : '0;
`ifdef EDGE_EVENT_TS_EN
    assign out_ts    = out_valid ? ts_mem[rd_ptr_q]    : '0;
`endif
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_fifo.sv
// Self-checking bench for edge_event_fifo: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_edge_event_fifo;

    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int TSW   = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           clr;
    logic [W-1:0]   d;
    logic           en;
    logic           ovf_clr;
    logic           out_ready;
    logic           out_valid;
    logic [W-1:0]   out_mask;
    logic [W-1:0]   out_level;
    logic [CW-1:0]  count;
    logic           overflow;
`ifdef EDGE_EVENT_TS_EN
    logic [TSW-1:0] out_ts;
`endif

    edge_event_fifo #(
        .W     (W),
        .DEPTH (DEPTH),
        .TSW   (TSW)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .d         (d),
        .en        (en),
        .ovf_clr   (ovf_clr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_mask  (out_mask),
        .out_level (out_level),
`ifdef EDGE_EVENT_TS_EN
        .out_ts    (out_ts),
`endif
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [W-1:0] mask;
        logic [W-1:0] level;
        int           ts;
    } ent_t;

    ent_t         m_fifo [$];
    logic [W-1:0] m_pipe [$];   // lane levels still in flight through the two-stage resync
    logic [W-1:0] m_prev;
    bit           m_ovf;
    int           m_ts;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic void model_reset();
        m_fifo.delete();
        m_pipe.delete();
        m_pipe.push_back('0);
        m_pipe.push_back('0);
        m_prev = '0;
        m_ovf  = 1'b0;
        m_ts   = 0;
    endfunction

    function automatic void model_edge();
        logic [W-1:0] seen;
        logic [W-1:0] chg;
        ent_t         e;
        bit           drop;
        if (clr) begin
            model_reset();
            return;
        end
        seen = m_pipe.pop_front();
        m_pipe.push_back(d);
        chg  = en ? (seen ^ m_prev) : '0;
        drop = 1'b0;
        if (m_fifo.size() > 0 && out_ready) begin
            e = m_fifo.pop_front();
        end
        if (chg != '0) begin
            if (m_fifo.size() < DEPTH) begin
                e.mask  = chg;
                e.level = seen;
                e.ts    = m_ts;
                m_fifo.push_back(e);
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (en) m_prev = seen;
        m_ts = (m_ts + 1) % (1 << TSW);
    endfunction

    task automatic check_all();
        bit ne;
        ne = (m_fifo.size() != 0);
        check_eq("valid", 32'(out_valid), 32'(ne));
        check_eq("count", 32'(count), 32'(m_fifo.size()));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("mask", 32'(out_mask), ne ? 32'(m_fifo[0].mask) : 32'd0);
        check_eq("level", 32'(out_level), ne ? 32'(m_fifo[0].level) : 32'd0);
`ifdef EDGE_EVENT_TS_EN
        check_eq("ts", 32'(out_ts), ne ? 32'(m_fifo[0].ts) : 32'd0);
`endif
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic reset_dut(input logic [W-1:0] dval);
        clr = 1'b1;
        d   = dval;
        tick();
        tick();
        clr = 1'b0;
    endtask

    task automatic async_clr();
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        check_eq("clr_count", 32'(count), 32'd0);
        check_eq("clr_valid", 32'(out_valid), 32'd0);
        tick();
        clr = 1'b0;
    endtask

    initial begin
        model_reset();
        clr = 1'b1; d = 4'b1010; en = 1'b1; ovf_clr = 1'b0; out_ready = 1'b0;

        // Reset and release with lanes already high.
        tick();
        tick();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        clr = 1'b0;
        tick();
        tick();
        check_eq("rel_early", 32'(out_valid), 32'd0);
        tick();
        check_eq("rel_valid", 32'(out_valid), 32'd1);
        check_eq("rel_mask", 32'(out_mask), 32'b1010);
        check_eq("rel_level", 32'(out_level), 32'b1010);
        tick();
        check_eq("rel_one", 32'(count), 32'd1);

        // Single toggle latency and pop.
        reset_dut('0);
        d = 4'b0001;
        tick();
        tick();
        check_eq("lat_early", 32'(out_valid), 32'd0);
        tick();
        check_eq("lat_valid", 32'(out_valid), 32'd1);
        check_eq("lat_mask", 32'(out_mask), 32'b0001);
        out_ready = 1'b1;
        tick();
        check_eq("pop_valid", 32'(out_valid), 32'd0);
        check_eq("pop_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Simultaneous lanes then partial change.
        reset_dut('0);
        d = 4'b1111;
        repeat (3) tick();
        check_eq("all_mask", 32'(out_mask), 32'b1111);
        check_eq("all_level", 32'(out_level), 32'b1111);
        d = 4'b0101;
        repeat (3) tick();
        check_eq("two_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        tick();
        check_eq("sec_mask", 32'(out_mask), 32'b1010);
        check_eq("sec_level", 32'(out_level), 32'b0101);
        tick();
        out_ready = 1'b0;

        // Overflow, sticky clear, and full push+pop.
        reset_dut('0);
        for (int i = 0; i < 5; i++) begin
            d = d ^ 4'b0001;
            tick();
        end
        tick();
        tick();
        check_eq("ovf_count", 32'(count), 32'd4);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("ovf_clr", 32'(overflow), 32'd0);
        d = d ^ 4'b0001;
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("full_pp_count", 32'(count), 32'd4);
        check_eq("full_pp_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;

        // Changes while disabled are reported as a net change.
        reset_dut('0);
        en = 1'b0;
        d = 4'b0010; tick();
        d = 4'b0000; tick();
        d = 4'b0100; tick();
        repeat (3) tick();
        check_eq("gate_none", 32'(count), 32'd0);
        en = 1'b1;
        tick();
        check_eq("gate_valid", 32'(out_valid), 32'd1);
        check_eq("gate_mask", 32'(out_mask), 32'b0100);

        // Asynchronous clear with entries queued.
        reset_dut('0);
        for (int i = 0; i < 3; i++) begin
            d = d ^ 4'b0001;
            tick();
        end
        tick();
        tick();
        check_eq("pre_clr_count", 32'(count), 32'd3);
        async_clr();

`ifdef EDGE_EVENT_TS_EN
        // Timestamps, including wrap of the free-running counter.
        reset_dut('0);
        out_ready = 1'b1;
        for (int i = 0; i < 600 && m_ts != 3; i++) tick();
        d = d ^ 4'b0001;
        repeat (3) tick();
        check_eq("ts_5", 32'(out_ts), 32'd5);
        for (int i = 0; i < 600 && m_ts != 253; i++) tick();
        d = d ^ 4'b0001;
        tick();
        d = d ^ 4'b0001;
        tick();
        tick();
        check_eq("ts_255", 32'(out_ts), 32'd255);
        tick();
        check_eq("ts_wrap", 32'(out_ts), 32'd0);
        out_ready = 1'b0;
`endif

        // Randomized traffic.
        reset_dut('0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) d = W'($urandom);
            en        = ($urandom_range(0, 4) != 0);
            out_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 79) == 0) begin
                async_clr();
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
